// File: rtl/ro_pkg.sv
// Shared constants and helpers for the readout slot scheduler.
// Latency: n/a (package).  Backpressure: n/a (package).
// Helpers operate on a 32-bit working vector; callers cast to their width.
package ro_pkg;

   localparam int N_CH_DEFAULT  = 19;
   localparam int IDX_W_DEFAULT = 5;
   localparam int TZ_W          = 32;

   // Trailing-zero count; returns TZ_W for an all-zero vector.
   function automatic logic [5:0] tz_index(input logic [TZ_W-1:0] v);
      logic [5:0] tz;
      tz = 6'(TZ_W);
      for (int i = TZ_W - 1; i >= 0; i--) begin
         if (v[i]) tz = 6'(i);
      end
      return tz;
   endfunction

   function automatic logic [TZ_W-1:0] onehot(input logic [4:0] idx);
      return {{(TZ_W-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/ro_tz_encoder.sv
// Combinational trailing-zero encoder used for slot-owner decode.
// Latency: 0 cycles.  Backpressure: none (pure combinational).
// Ports: vec_i (N_CH bits) in; idx_o = trailing-zero count (0 when zero), zero_o = vec_i is all zero.
module ro_tz_encoder
   import ro_pkg::*;
#(
   parameter int N_CH  = N_CH_DEFAULT,
   parameter int IDX_W = IDX_W_DEFAULT
) (
   input  logic [N_CH-1:0]  vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             zero_o
);

   logic [TZ_W-1:0] vec_ext;
   logic [5:0]      tz;

   assign vec_ext = TZ_W'(vec_i);
   assign tz      = tz_index(vec_ext);
   assign zero_o  = (vec_i == '0);
   assign idx_o   = zero_o ? '0 : IDX_W'(tz);

endmodule

// File: rtl/ro_slot_scheduler.sv
// Time-division owner of the shared readout pair: channel k gets every 2^(k+1)-th slot.
// Latency: enable -> grant 1 cycle, grant -> out_valid 1 cycle (2 total).
// Backpressure: none; enable=0 freezes the slot counter and idles the grant bus.
// Ports: clk_master/reset (async, active high), enable, ch_mask, in_eve, in_pol_eve in;
//        grant, slot_idx, frame_start (stage 1) and out_valid/out_eve/out_pol_eve/out_idx (stage 2) out.
module ro_slot_scheduler
   import ro_pkg::*;
#(
   parameter int N_CH  = N_CH_DEFAULT,
   parameter int IDX_W = IDX_W_DEFAULT
) (
   input  logic             clk_master,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_CH-1:0]  ch_mask,
   input  logic [N_CH-1:0]  in_eve,
   input  logic [N_CH-1:0]  in_pol_eve,
   output logic [N_CH-1:0]  grant,
   output logic [IDX_W-1:0] slot_idx,
   output logic             out_valid,
   output logic             out_eve,
   output logic             out_pol_eve,
   output logic [IDX_W-1:0] out_idx,
   output logic             frame_start
);

   logic [N_CH-1:0]  cnt_q, cnt_d, cnt_next;
   logic [N_CH-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
   logic             frame_q, frame_d;
   logic             vld_q, vld_d;
   logic             eve_q, eve_d;
   logic             pol_q, pol_d;
   logic [IDX_W-1:0] oidx_q, oidx_d;

   logic [IDX_W-1:0] owner;
   logic             owner_none;

   assign cnt_next = cnt_q + N_CH'(1);

   // Owner of the slot being entered is the trailing-zero count of the new counter value.
   ro_tz_encoder #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_tz (
      .vec_i  (cnt_next),
      .idx_o  (owner),
      .zero_o (owner_none)
   );

   always_comb begin
      cnt_d      = cnt_q;
      grant_d    = '0;
      slot_idx_d = '0;
      frame_d    = 1'b0;
      vld_d      = 1'b0;
      eve_d      = eve_q;
      pol_d      = pol_q;
      oidx_d     = oidx_q;

      if (enable) begin
         cnt_d   = cnt_next;
         frame_d = owner_none;
         if (!owner_none && ch_mask[owner]) begin
            grant_d    = N_CH'(onehot(5'(owner)));
            slot_idx_d = owner;
         end
      end

      // Stage 2 samples the channel that held the bus during the current cycle.
      if (grant_q != '0) begin
         vld_d  = 1'b1;
         eve_d  = in_eve[slot_idx_q];
         pol_d  = in_pol_eve[slot_idx_q];
         oidx_d = slot_idx_q;
      end
   end

   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         grant_q    <= '0;
         slot_idx_q <= '0;
         frame_q    <= 1'b0;
         vld_q      <= 1'b0;
         eve_q      <= 1'b0;
         pol_q      <= 1'b0;
         oidx_q     <= '0;
      end else begin
         cnt_q      <= cnt_d;
         grant_q    <= grant_d;
         slot_idx_q <= slot_idx_d;
         frame_q    <= frame_d;
         vld_q      <= vld_d;
         eve_q      <= eve_d;
         pol_q      <= pol_d;
         oidx_q     <= oidx_d;
      end
   end

   assign grant       = grant_q;
   assign slot_idx    = slot_idx_q;
   assign frame_start = frame_q;
   assign out_valid   = vld_q;
   assign out_eve     = eve_q;
   assign out_pol_eve = pol_q;
   assign out_idx     = oidx_q;

endmodule

// File: tb/tb_ro_slot_scheduler.sv
// Bench for ro_slot_scheduler: a 4-channel instance checked every cycle against a
// slot-arithmetic model plus literal expectations, and a 10-channel instance for frame counts.
module tb_ro_slot_scheduler;

   localparam int N  = 4;
   localparam int W  = 3;
   localparam int N2 = 10;
   localparam int W2 = 4;

   logic          clk, rst, en, en10;
   logic [N-1:0]  mask, ie, ip;
   logic [N-1:0]  grant;
   logic [W-1:0]  slot_idx, out_idx;
   logic          out_valid, out_eve, out_pol_eve, frame_start;

   logic [N2-1:0] grant10, slot_unused10;
   logic [W2-1:0] slot_idx10, out_idx10;
   logic          out_valid10, out_eve10, out_pol10, frame10;

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;

   ro_slot_scheduler #(.N_CH(N), .IDX_W(W)) dut (
      .clk_master (clk), .reset (rst), .enable (en), .ch_mask (mask),
      .in_eve (ie), .in_pol_eve (ip), .grant (grant), .slot_idx (slot_idx),
      .out_valid (out_valid), .out_eve (out_eve), .out_pol_eve (out_pol_eve),
      .out_idx (out_idx), .frame_start (frame_start)
   );

   assign slot_unused10 = '1;

   ro_slot_scheduler #(.N_CH(N2), .IDX_W(W2)) dut10 (
      .clk_master (clk), .reset (rst), .enable (en10), .ch_mask (slot_unused10),
      .in_eve ('0), .in_pol_eve ('0), .grant (grant10), .slot_idx (slot_idx10),
      .out_valid (out_valid10), .out_eve (out_eve10), .out_pol_eve (out_pol10),
      .out_idx (out_idx10), .frame_start (frame10)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // Model: slot number s = counter value after the edge; owner = trailing zeros of s.
   int       m_cnt, m_sidx, m_oidx;
   logic [N-1:0] m_grant;
   bit       m_fs, m_vld, m_eve, m_pol;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; m_grant = '0; m_sidx = 0; m_fs = 0;
         m_vld = 0; m_eve = 0; m_pol = 0; m_oidx = 0;
      end else begin
         if (m_grant != 0) begin
            m_vld = 1; m_eve = ie[m_sidx]; m_pol = ip[m_sidx]; m_oidx = m_sidx;
         end else begin
            m_vld = 0;
         end
         m_grant = '0; m_sidx = 0; m_fs = 0;
         if (en) begin
            int s, t;
            s = (m_cnt + 1) % (1 << N);
            m_fs = (s == 0);
            if (s != 0) begin
               t = 0;
               while (((s >> t) & 1) == 0) t++;
               if (mask[t]) begin
                  m_grant = N'(1 << t);
                  m_sidx  = t;
               end
            end
            m_cnt = s;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         logic [13:0] got, exp;
         got = {grant, slot_idx, frame_start, out_valid, out_eve, out_pol_eve, out_idx};
         exp = {m_grant, W'(m_sidx), m_fs, m_vld, m_eve, m_pol, W'(m_oidx)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL cycle_cmp at %0t: got %b expected %b", $time, got, exp);
         end
      end
   end

   logic [N-1:0] exp_seq [16];
   int cnt10 [N2];
   logic [N2-1:0] prev10;
   bit seen_frame;

   initial begin
      exp_seq = '{4'h1, 4'h2, 4'h1, 4'h4, 4'h1, 4'h2, 4'h1, 4'h8,
                  4'h1, 4'h2, 4'h1, 4'h4, 4'h1, 4'h2, 4'h1, 4'h0};
      rst = 1; en = 0; en10 = 0; mask = 4'hF; ie = 4'b0100; ip = 4'b1000;
      #2;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_slot_idx", 32'(slot_idx), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_outs", 32'({out_eve, out_pol_eve, out_idx}), 0);
      chk("rst_frame", 32'(frame_start), 0);

      // Full frame: grant sequence and frame_start position.
      @(negedge clk);
      rst = 0; en = 1; chk_on = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("seq_grant", 32'(grant), 32'(exp_seq[i]));
         chk("seq_frame", 32'(frame_start), (i == 15) ? 1 : 0);
      end
      // Second frame: data tags carried for channels 2 and 3.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (out_valid) begin
            if (out_idx == 2)      chk("data_ch2", 32'({out_eve, out_pol_eve}), 2);
            else if (out_idx == 3) chk("data_ch3", 32'({out_eve, out_pol_eve}), 1);
            else                   chk("data_other", 32'({out_eve, out_pol_eve}), 0);
         end
      end

      // Channel 0 masked for a full frame.
      mask = 4'b1110;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("mask_ch0", 32'(grant[0]), 0);
      end
      mask = 4'hF;

      // Pause after slot 5, resume on slot 6.
      @(negedge clk); rst = 1; en = 0;
      @(negedge clk); rst = 0; en = 1;
      repeat (5) @(negedge clk);
      chk("slot5_grant", 32'(grant), 1);
      en = 0;
      @(negedge clk);
      chk("pause_grant", 32'(grant), 0);
      chk("pause_valid_lag", 32'(out_valid), 1);
      @(negedge clk);
      chk("pause_valid", 32'(out_valid), 0);
      repeat (3) @(negedge clk);
      en = 1;
      @(negedge clk);
      chk("resume_slot6", 32'(grant), 32'h2);
      @(negedge clk);
      chk("resume_slot7", 32'(grant), 32'h1);

      // Asynchronous reset during a channel-3 grant.
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      repeat (8) @(negedge clk);
      chk("pre_rst_ch3", 32'(grant), 32'h8);
      chk("pre_rst_valid", 32'(out_valid), 1);
      #2 rst = 1;
      #1;
      chk("async_grant", 32'(grant), 0);
      chk("async_valid", 32'(out_valid), 0);
      chk("async_frame", 32'(frame_start), 0);
      @(negedge clk); rst = 0;
      @(negedge clk);
      chk("post_rst_first", 32'(grant), 32'h1);
      en = 0;
      chk_on = 0;

      // 10-channel frame: one-hot, no back-to-back owner, per-channel slot counts.
      for (int k = 0; k < N2; k++) cnt10[k] = 0;
      prev10 = '0;
      seen_frame = 0;
      en10 = 1;
      for (int c = 0; c < (1 << N2) + 10 && !seen_frame; c++) begin
         @(negedge clk);
         chk("onehot10", 32'($countones(grant10) <= 1), 1);
         chk("no_repeat10", 32'(grant10 & prev10), 0);
         for (int k = 0; k < N2; k++) if (grant10[k]) cnt10[k]++;
         prev10 = grant10;
         if (frame10) seen_frame = 1;
      end
      chk("frame10_seen", 32'(seen_frame), 1);
      for (int k = 0; k < N2; k++) chk("frame10_count", 32'(cnt10[k]), 32'(1 << (N2 - 1 - k)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ro_slot_scheduler.md
Name: ro_slot_scheduler

Overview:
- Time-division scheduler that shares one readout output pair (event, polarity-event) between N_CH cochlea channel readout blocks.
- Each cycle a free-running binary slot counter selects the owning channel. Channel k owns the bus once every 2^(k+1) cycles, so slot rate halves per channel index, matching the octave-spaced core clocks.
- Drives a registered one-hot grant bus to the per-channel tristate enables, samples the selected channel's data, and presents it with a valid/index tag.
- Sits between the channel readout blocks and the chip output pads, clocked by clk_master.

Parameters:
- N_CH, 19, number of channels sharing the readout bus; also the slot counter width.
- IDX_W, 5, width of the channel index; must satisfy 2^IDX_W >= N_CH.

Ports:
- clk_master  input  1  master clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when 1 the slot counter advances; when 0 it holds.
- ch_mask  input  N_CH  per-channel enable; a masked channel's slots are idle.
- in_eve  input  N_CH  per-channel event bit.
- in_pol_eve  input  N_CH  per-channel polarity-event bit.
- grant  output  N_CH  registered one-hot (or zero) bus-ownership strobe.
- slot_idx  output  IDX_W  index of the currently granted channel; 0 when no grant.
- out_valid  output  1  out_eve, out_pol_eve and out_idx are valid this cycle.
- out_eve  output  1  sampled event of the granted channel.
- out_pol_eve  output  1  sampled polarity event of the granted channel.
- out_idx  output  IDX_W  channel index of the sampled data.
- frame_start  output  1  one-cycle pulse on the counter wrap slot.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): cnt=0, grant=0, slot_idx=0, out_valid=0, out_eve=0, out_pol_eve=0, out_idx=0, frame_start=0.
- Counter: on each posedge with enable=1, cnt <= cnt+1 modulo 2^N_CH. With enable=0, cnt holds.
- Slot decode on cnt_next=cnt+1:
  - t = trailing-zero count of cnt_next.
  - If cnt_next != 0, channel t owns the slot.
  - If cnt_next == 0 (wrap), the slot is idle and frame_start is 1.
- Stage 1 (registered, same edge as the counter update):
  - If enable=1 and the slot owner t exists with ch_mask[t]=1: grant <= onehot(t), slot_idx <= t.
  - Otherwise: grant <= 0, slot_idx <= 0.
  - frame_start <= enable & (cnt_next==0).
- Stage 2 (next edge):
  - If grant != 0: out_eve <= in_eve[slot_idx], out_pol_eve <= in_pol_eve[slot_idx], out_idx <= slot_idx, out_valid <= 1.
  - Otherwise: out_valid <= 0. out_eve, out_pol_eve and out_idx hold their last values.
- Latency:
  - Enable sampled high → grant 1 cycle later.
  - Data is sampled at the end of the grant cycle.
  - out_valid goes high 2 cycles after the enabling edge.
- Grant invariants:
  - grant is never more than one-hot.
  - No channel is granted in two consecutive cycles (for N_CH>=2).
  - Over one frame of 2^N_CH cycles, channel k receives exactly 2^(N_CH-k-1) slots, plus one idle slot per frame.
- enable deassertion: grant is 0 on the next edge and out_valid is 0 one edge later. The counter resumes from the held value with no skipped or repeated slot.
- ch_mask changes take effect for the slot decoded at the next edge. A grant already issued is not revoked.
- Inputs in_eve and in_pol_eve are synchronous to clk_master. No synchronizer is inside this block.

Decomposition:
- Shared package ro_pkg:
  - N_CH_DEFAULT=19
  - IDX_W_DEFAULT=5
  - function tz_index(vector) returning the trailing-zero count
  - function onehot(idx)
- One sub-module: ro_tz_encoder.
  - Combinational trailing-zero count of an N_CH-bit vector.
  - Outputs idx[IDX_W-1:0] and zero (all-zero flag).
  - Instantiated once on cnt_next.

Test Plan:
- Reset then enable=1, N_CH=4, ch_mask=4'hF → grant channel sequence 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,idle. frame_start=1 only on the 16th slot; the pattern repeats.
- Same setup, in_eve=4'b0100, in_pol_eve=4'b1000 → out_valid with out_idx=2 carries out_eve=1 and out_pol_eve=0. out_idx=3 carries out_eve=0 and out_pol_eve=1. All other indices carry 0/0. out_valid lags grant by exactly 1 cycle.
- ch_mask=4'b1110 → the 8 channel-0 slots per frame give grant=0 and out_valid=0 one cycle later. Channels 1–3 keep the same slot positions.
- enable low for 5 cycles after slot 5 → grant=0 from the next edge. On resume the next grant is slot 6 (channel 1), with no slot lost or repeated.
- Assert reset during a channel-3 grant → grant, out_valid and frame_start go 0 immediately, without a clock. After release the first grant is channel 0.
- N_CH=19 for 2^19+10 cycles → assertions hold every cycle: grant is at most one-hot, and per-frame counts are 2^(18-k) per channel k.
